mem_access_queue: RTL and testbench
===================================

Name: mem_access_queue

Overview:
- Parametrised data-side access engine between the MEM stage and the SRAM-like data bus (req/addr_ok/data_ok).
- Generalises single-transaction load/store handling in three ways:
  - up to DEPTH outstanding transactions, with in-order responses;
  - configurable physical-address mask and uncached-segment bit;
  - registered issue slot that allows back-to-back issue.
- Performs alignment checking, store-data lane replication and load byte/half extraction with sign or zero extension.

Parameters:
DEPTH, 2, maximum accepted-but-not-returned transactions (power of two, >=1)
TAG_W, 5, width of destination tag carried with each request (register address)
PHYS_BITS, 29, low address bits kept as physical address; upper bits forced to 0
UNCACHED_BIT, 29, virtual address bit selecting uncached access

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid_i  in  1  MEM stage presents an access
req_ready_o  out  1  access accepted into issue slot this cycle
req_wr_i  in  1  1=store, 0=load
req_size_i  in  2  0=byte, 1=half, 2=word, 3=illegal
req_signed_i  in  1  sign-extend load result
req_addr_i  in  32  virtual address
req_wdata_i  in  32  store data (low bytes significant)
req_tag_i  in  TAG_W  destination tag
misaligned_o  out  1  address error on presented request (combinational)
misaligned_store_o  out  1  qualifies misaligned_o: 1=AdES, 0=AdEL
rsp_valid_o  out  1  transaction completed this cycle
rsp_wr_o  out  1  completed transaction was a store
rsp_tag_o  out  TAG_W  tag of completed transaction
rsp_rdata_o  out  32  extended load data (0 for stores)
busy_o  out  1  issue slot occupied or any transaction pending
data_req  out  1  bus request
data_wr  out  1  bus write
data_size  out  2  bus size
data_addr  out  32  bus physical address
data_wdata  out  32  bus write data
data_uncached  out  1  uncached attribute
data_rdata  in  32  bus read data
data_addr_ok  in  1  bus accepted address
data_data_ok  in  1  bus returned data / write done

Behaviour:
Reset
- rst clears the issue slot, the pending FIFO and its count immediately.
- Held at 0 during reset: all outputs, including req_ready_o.
- Bus handshakes in flight at reset are abandoned.
- data_data_ok arriving while count==0 is ignored: rsp_valid_o=0.

Misaligned / illegal requests
- Condition: req_valid_i && (size==3 || (size==1 && addr[0]) || (size==2 && addr[1:0]!=0)).
- Response: misaligned_o=1, misaligned_store_o=req_wr_i, and the request is never accepted.
- Illegal size also raises misaligned_o.

Issue slot
- Accept when req_valid_i && req_ready_o && !misaligned_o.
- req_ready_o = !slot_valid || (data_req && data_addr_ok).
- Captured at accept:
  - physical address = {0, addr[PHYS_BITS-1:0]};
  - uncached = addr[UNCACHED_BIT];
  - wr, size, signed, tag, addr[1:0];
  - wdata replicated per size: byte x4, half x2, word as-is.
- data_req = slot_valid && (count < DEPTH).
  - Issue latency: accept in cycle N gives data_req in cycle N+1 at the earliest.
- Once data_req rises, it and data_wr/size/addr/wdata/uncached stay stable until data_addr_ok. Count never increases while the slot waits, so data_req cannot fall.

Pending FIFO
- On data_req && data_addr_ok: push {wr, size, signed, tag, addr[1:0]}, count++.
- On data_data_ok && count!=0: pop head, count--.
- Simultaneous push and pop: count unchanged.
- Pointers wrap modulo DEPTH.
- count==DEPTH blocks data_req but not acceptance into an empty slot.

Response (combinational, same cycle as data_data_ok)
- rsp_valid_o=1; rsp_tag_o and rsp_wr_o come from the FIFO head.
- Load extraction uses head addr[1:0]:
  - byte selects lane addr[1:0];
  - half selects lane addr[1];
  - extension per signed.
- Stores: rsp_rdata_o=0.
- Responses are strictly in issue order.

busy_o
- busy_o = slot_valid || count!=0.

Test Plan:
- Load word to 0x8000_0010, addr_ok same cycle as req, data_ok 2 cycles later with rdata 0xDEADBEEF -> data_addr=0x0000_0010, uncached=0, rsp_valid_o with rdata 0xDEADBEEF and the request's tag; busy_o drops the next cycle.
- LB signed at 0xA000_0003, rdata 0x80FF_FFFF -> data_uncached=1, rsp_rdata_o=0xFFFF_FF80. Repeat as LHU at offset 2 -> 0x0000_80FF.
- DEPTH=2: three loads back-to-back, addr_ok always 1, data_ok withheld -> data_req low for the third while count==2. Third issues in the cycle after the first data_ok. Responses return tags in issue order.
- SH at 0x8000_0001 -> misaligned_o=1, misaligned_store_o=1, req_ready_o irrelevant, no data_req. SB 0xAB -> data_wdata=0xABABABAB.
- Simultaneous push and pop at count==1 -> count stays 1. Spurious data_ok with count==0 -> no rsp_valid_o.
- Assert rst while data_req is waiting on addr_ok and one transaction is pending -> all outputs 0 immediately. After release, a new load completes normally.

Source files
------------

// File: rtl/mem_access_queue.sv
// Data-side access engine between the MEM stage and an SRAM-like data bus.
// Holds one registered issue slot plus up to DEPTH in-order outstanding transactions.
module mem_access_queue #(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned TAG_W        = 5,
    parameter int unsigned PHYS_BITS    = 29,
    parameter int unsigned UNCACHED_BIT = 29
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_wr_i,
    input  logic [1:0]       req_size_i,
    input  logic             req_signed_i,
    input  logic [31:0]      req_addr_i,
    input  logic [31:0]      req_wdata_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             misaligned_o,
    output logic             misaligned_store_o,
    output logic             rsp_valid_o,
    output logic             rsp_wr_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic [31:0]      rsp_rdata_o,
    output logic             busy_o,
    output logic             data_req,
    output logic             data_wr,
    output logic [1:0]       data_size,
    output logic [31:0]      data_addr,
    output logic [31:0]      data_wdata,
    output logic             data_uncached,
    input  logic [31:0]      data_rdata,
    input  logic             data_addr_ok,
    input  logic             data_data_ok
);

    localparam int unsigned      PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned      CNT_W     = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [31:0]      PHYS_MASK = (PHYS_BITS >= 32) ? 32'hFFFF_FFFF
                                           : ((32'h1 << PHYS_BITS) - 32'h1);

    typedef struct packed {
        logic             wr;
        logic [1:0]       size;
        logic             sgn;
        logic [TAG_W-1:0] tag;
        logic [1:0]       off;
    } entry_t;

    entry_t           slot_q, slot_d;
    logic             slot_valid_q, slot_valid_d;
    logic [31:0]      slot_addr_q, slot_addr_d;
    logic [31:0]      slot_wdata_q, slot_wdata_d;
    logic             slot_unc_q, slot_unc_d;

    entry_t           fifo_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             addr_err;
    logic             issue;
    logic             accept;
    logic             pop;
    logic [31:0]      wdata_rep;
    entry_t           head;
    logic [7:0]       lane_b;
    logic [15:0]      lane_h;

    always_comb begin
        addr_err = req_valid_i && ((req_size_i == 2'd3) ||
                                   (req_size_i == 2'd1 && req_addr_i[0]) ||
                                   (req_size_i == 2'd2 && req_addr_i[1:0] != 2'b00));
        misaligned_o       = !rst && addr_err;
        misaligned_store_o = !rst && addr_err && req_wr_i;

        // Count cannot rise while the slot waits, so data_req stays up until addr_ok.
        data_req    = slot_valid_q && (count_q < DEPTH_C);
        issue       = data_req && data_addr_ok;
        req_ready_o = !rst && (!slot_valid_q || issue);
        accept      = req_valid_i && req_ready_o && !addr_err;
        pop         = data_data_ok && (count_q != '0);
        busy_o      = slot_valid_q || (count_q != '0);

        data_wr       = slot_q.wr;
        data_size     = slot_q.size;
        data_addr     = slot_addr_q;
        data_wdata    = slot_wdata_q;
        data_uncached = slot_unc_q;
    end

    always_comb begin
        case (req_size_i)
            2'd0:    wdata_rep = {4{req_wdata_i[7:0]}};
            2'd1:    wdata_rep = {2{req_wdata_i[15:0]}};
            default: wdata_rep = req_wdata_i;
        endcase
    end

    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_d       = slot_q;
        slot_addr_d  = slot_addr_q;
        slot_wdata_d = slot_wdata_q;
        slot_unc_d   = slot_unc_q;
        if (issue) begin
            slot_valid_d = 1'b0;
        end
        if (accept) begin
            slot_valid_d = 1'b1;
            slot_d.wr    = req_wr_i;
            slot_d.size  = req_size_i;
            slot_d.sgn   = req_signed_i;
            slot_d.tag   = req_tag_i;
            slot_d.off   = req_addr_i[1:0];
            slot_addr_d  = req_addr_i & PHYS_MASK;
            slot_wdata_d = wdata_rep;
            slot_unc_d   = req_addr_i[UNCACHED_BIT];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (issue) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({issue, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid_q <= 1'b0;
            slot_q       <= '0;
            slot_addr_q  <= '0;
            slot_wdata_q <= '0;
            slot_unc_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_q       <= slot_d;
            slot_addr_q  <= slot_addr_d;
            slot_wdata_q <= slot_wdata_d;
            slot_unc_q   <= slot_unc_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Entry storage needs no reset: the head is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (issue) begin
            fifo_q[wr_ptr_q] <= slot_q;
        end
    end

    always_comb begin
        head        = fifo_q[rd_ptr_q];
        rsp_valid_o = pop;
        rsp_wr_o    = 1'b0;
        rsp_tag_o   = '0;
        rsp_rdata_o = '0;
        case (head.off)
            2'd0:    lane_b = data_rdata[7:0];
            2'd1:    lane_b = data_rdata[15:8];
            2'd2:    lane_b = data_rdata[23:16];
            default: lane_b = data_rdata[31:24];
        endcase
        lane_h = head.off[1] ? data_rdata[31:16] : data_rdata[15:0];
        if (pop) begin
            rsp_wr_o  = head.wr;
            rsp_tag_o = head.tag;
            if (!head.wr) begin
                case (head.size)
                    2'd0:    rsp_rdata_o = {{24{head.sgn & lane_b[7]}}, lane_b};
                    2'd1:    rsp_rdata_o = {{16{head.sgn & lane_h[15]}}, lane_h};
                    default: rsp_rdata_o = data_rdata;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_access_queue.sv
// Self-checking bench for mem_access_queue: directed bus handshakes with a response scoreboard.
module tb_mem_access_queue;

    localparam int unsigned TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid_i, req_wr_i, req_signed_i;
    logic [1:0]       req_size_i;
    logic [31:0]      req_addr_i, req_wdata_i;
    logic [TAG_W-1:0] req_tag_i;
    logic             req_ready_o, misaligned_o, misaligned_store_o;
    logic             rsp_valid_o, rsp_wr_o, busy_o;
    logic [TAG_W-1:0] rsp_tag_o;
    logic [31:0]      rsp_rdata_o;
    logic             data_req, data_wr, data_uncached;
    logic [1:0]       data_size;
    logic [31:0]      data_addr, data_wdata, data_rdata;
    logic             data_addr_ok, data_data_ok;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic             wr;
        logic [31:0]      rd;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    mem_access_queue #(
        .DEPTH(2), .TAG_W(TAG_W), .PHYS_BITS(29), .UNCACHED_BIT(29)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_wr_i(req_wr_i),
        .req_size_i(req_size_i), .req_signed_i(req_signed_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_tag_i(req_tag_i),
        .misaligned_o(misaligned_o), .misaligned_store_o(misaligned_store_o),
        .rsp_valid_o(rsp_valid_o), .rsp_wr_o(rsp_wr_o), .rsp_tag_o(rsp_tag_o),
        .rsp_rdata_o(rsp_rdata_o), .busy_o(busy_o),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_uncached(data_uncached),
        .data_rdata(data_rdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Every response is compared against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid_o) begin
            if (sb_q.size() == 0) begin
                check_eq("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("rsp_tag", 32'(rsp_tag_o), 32'(e.tag));
                check_eq("rsp_wr", 32'(rsp_wr_o), 32'(e.wr));
                check_eq("rsp_rdata", rsp_rdata_o, e.rd);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic wr, input logic [1:0] sz, input logic sg,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [TAG_W-1:0] tag);
        req_valid_i  = 1'b1;
        req_wr_i     = wr;
        req_size_i   = sz;
        req_signed_i = sg;
        req_addr_i   = addr;
        req_wdata_i  = wd;
        req_tag_i    = tag;
    endtask

    task automatic single_access(input logic wr, input logic [1:0] sz, input logic sg,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [TAG_W-1:0] tag, input logic [31:0] bus_rd,
                                 input logic [31:0] exp_rd, input logic [31:0] exp_wd,
                                 input int unsigned gap);
        int unsigned n;
        exp_t e;
        drive_req(wr, sz, sg, addr, wd, tag);
        #1;
        check_eq("acc_ready", 32'(req_ready_o), 32'd1);
        check_eq("acc_misaligned", 32'(misaligned_o), 32'd0);
        e.tag = tag; e.wr = wr; e.rd = exp_rd;
        sb_q.push_back(e);
        tick;
        req_valid_i = 1'b0;
        n = 0;
        while (!data_req && n < 20) begin
            tick;
            n++;
        end
        check_eq("issue_req", 32'(data_req), 32'd1);
        check_eq("bus_addr", data_addr, addr & 32'h1FFF_FFFF);
        check_eq("bus_uncached", 32'(data_uncached), 32'(addr[29]));
        check_eq("bus_wr", 32'(data_wr), 32'(wr));
        check_eq("bus_size", 32'(data_size), 32'(sz));
        if (wr) check_eq("bus_wdata", data_wdata, exp_wd);
        data_addr_ok = 1'b1;
        tick;
        data_addr_ok = 1'b0;
        repeat (gap) tick;
        data_data_ok = 1'b1;
        data_rdata   = bus_rd;
        tick;
        data_data_ok = 1'b0;
        #1;
        check_eq("idle_after", 32'(busy_o), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid_i = 1'b0; req_wr_i = 1'b0; req_size_i = 2'd0; req_signed_i = 1'b0;
        req_addr_i = '0; req_wdata_i = '0; req_tag_i = '0;
        data_rdata = '0; data_addr_ok = 1'b0; data_data_ok = 1'b0;

        // Reset: outputs held low even with live-looking inputs.
        tick;
        drive_req(1'b0, 2'd2, 1'b0, 32'h8000_0000, '0, 5'd1);
        data_data_ok = 1'b1;
        #1;
        check_eq("rst_ready", 32'(req_ready_o), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_data_req", 32'(data_req), 32'd0);
        req_size_i = 2'd3;
        #1;
        check_eq("rst_misaligned", 32'(misaligned_o), 32'd0);
        tick;
        req_valid_i = 1'b0; data_data_ok = 1'b0;
        rst = 1'b0;
        tick;

        // Single accesses across sizes, lanes, extension and segments.
        single_access(1'b0, 2'd2, 1'b0, 32'h8000_0010, '0, 5'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, '0, 1);
        single_access(1'b0, 2'd0, 1'b1, 32'hA000_0003, '0, 5'd4, 32'h80FF_FFFF, 32'hFFFF_FF80, '0, 0);
        single_access(1'b0, 2'd1, 1'b0, 32'hA000_0002, '0, 5'd5, 32'h80FF_FFFF, 32'h0000_80FF, '0, 0);
        single_access(1'b1, 2'd0, 1'b0, 32'h8000_0005, 32'h0000_00AB, 5'd6, 32'h1234_5678, 32'h0, 32'hABAB_ABAB, 0);
        single_access(1'b1, 2'd1, 1'b0, 32'h8000_0006, 32'h5555_1234, 5'd7, 32'h0, 32'h0, 32'h1234_1234, 2);
        single_access(1'b0, 2'd1, 1'b1, 32'h8000_0000, '0, 5'd8, 32'h1234_8001, 32'hFFFF_8001, '0, 0);
        single_access(1'b0, 2'd0, 1'b0, 32'h8000_0001, '0, 5'd9, 32'h0000_F000, 32'h0000_00F0, '0, 0);
        single_access(1'b1, 2'd2, 1'b0, 32'h8000_0008, 32'hCAFE_F00D, 5'd10, 32'h0, 32'h0, 32'hCAFE_F00D, 0);
        single_access(1'b0, 2'd2, 1'b0, 32'hBFC0_0004, '0, 5'd11, 32'h0BAD_F00D, 32'h0BAD_F00D, '0, 0);

        // Misaligned and illegal-size requests are flagged and never issued.
        drive_req(1'b1, 2'd1, 1'b0, 32'h8000_0001, 32'h1234, 5'd12);
        #1;
        check_eq("sh_mis", 32'(misaligned_o), 32'd1);
        check_eq("sh_mis_store", 32'(misaligned_store_o), 32'd1);
        tick;
        check_eq("sh_no_req", 32'(data_req), 32'd0);
        drive_req(1'b0, 2'd2, 1'b0, 32'h8000_0002, '0, 5'd13);
        #1;
        check_eq("lw_mis", 32'(misaligned_o), 32'd1);
        check_eq("lw_mis_store", 32'(misaligned_store_o), 32'd0);
        tick;
        req_size_i = 2'd3; req_addr_i = 32'h8000_0000;
        #1;
        check_eq("size3_mis", 32'(misaligned_o), 32'd1);
        tick;
        req_valid_i = 1'b0;
        #1;
        check_eq("mis_no_req", 32'(data_req), 32'd0);
        check_eq("mis_not_busy", 32'(busy_o), 32'd0);

        // Three back-to-back loads with DEPTH=2; addr_ok held high, data_ok withheld.
        data_addr_ok = 1'b1;
        begin
            exp_t e;
            drive_req(1'b0, 2'd2, 1'b0, 32'h8000_0100, '0, 5'd20);
            #1;
            check_eq("b2b_rdy0", 32'(req_ready_o), 32'd1);
            e.tag = 5'd20; e.wr = 1'b0; e.rd = 32'h1111_0000; sb_q.push_back(e);
            tick;
            drive_req(1'b0, 2'd2, 1'b0, 32'h8000_0104, '0, 5'd21);
            #1;
            check_eq("b2b_rdy1", 32'(req_ready_o), 32'd1);
            check_eq("b2b_req1", 32'(data_req), 32'd1);
            e.tag = 5'd21; e.rd = 32'h2222_0000; sb_q.push_back(e);
            tick;
            drive_req(1'b0, 2'd2, 1'b0, 32'h8000_0108, '0, 5'd22);
            #1;
            check_eq("b2b_rdy2", 32'(req_ready_o), 32'd1);
            e.tag = 5'd22; e.rd = 32'h3333_0000; sb_q.push_back(e);
        end
        tick;
        req_valid_i = 1'b0;
        #1;
        check_eq("full_block", 32'(data_req), 32'd0);
        check_eq("full_busy", 32'(busy_o), 32'd1);
        tick;
        check_eq("full_hold", 32'(data_req), 32'd0);
        check_eq("full_hold_addr", data_addr, 32'h0000_0108);
        data_data_ok = 1'b1; data_rdata = 32'h1111_0000;
        tick;
        data_rdata = 32'h2222_0000;
        #1;
        check_eq("third_issue", 32'(data_req), 32'd1);
        tick;
        data_data_ok = 1'b0; data_addr_ok = 1'b0;
        #1;
        check_eq("pushpop_busy", 32'(busy_o), 32'd1);
        check_eq("pushpop_slot_free", 32'(data_req), 32'd0);
        data_data_ok = 1'b1; data_rdata = 32'h3333_0000;
        tick;
        data_data_ok = 1'b0;
        #1;
        check_eq("drain_idle", 32'(busy_o), 32'd0);

        // Spurious data_ok with nothing outstanding.
        data_data_ok = 1'b1;
        #1;
        check_eq("spurious_rsp", 32'(rsp_valid_o), 32'd0);
        tick;
        data_data_ok = 1'b0;

        // Asynchronous reset with one pending transaction and a waiting slot.
        drive_req(1'b0, 2'd2, 1'b0, 32'h8000_0200, '0, 5'd24);
        tick;
        req_valid_i = 1'b0; data_addr_ok = 1'b1;
        tick;
        data_addr_ok = 1'b0;
        drive_req(1'b1, 2'd2, 1'b0, 32'hA000_0204, 32'h7777_7777, 5'd25);
        tick;
        req_valid_i = 1'b0;
        #1;
        check_eq("pre_rst_req", 32'(data_req), 32'd1);
        #1;
        rst = 1'b1;
        drive_req(1'b0, 2'd3, 1'b0, 32'h8000_0000, '0, 5'd26);
        data_data_ok = 1'b1;
        #1;
        check_eq("arst_data_req", 32'(data_req), 32'd0);
        check_eq("arst_busy", 32'(busy_o), 32'd0);
        check_eq("arst_ready", 32'(req_ready_o), 32'd0);
        check_eq("arst_misaligned", 32'(misaligned_o), 32'd0);
        check_eq("arst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check_eq("arst_addr", data_addr, 32'h0);
        check_eq("arst_wdata", data_wdata, 32'h0);
        check_eq("arst_uncached", 32'(data_uncached), 32'd0);
        check_eq("arst_wr", 32'(data_wr), 32'd0);
        tick;
        req_valid_i = 1'b0; data_data_ok = 1'b0;
        tick;
        rst = 1'b0;
        tick;
        data_data_ok = 1'b1;
        #1;
        check_eq("post_rst_spurious", 32'(rsp_valid_o), 32'd0);
        tick;
        data_data_ok = 1'b0;
        single_access(1'b0, 2'd2, 1'b0, 32'h8000_0300, '0, 5'd27, 32'h5A5A_A5A5, 32'h5A5A_A5A5, '0, 1);

        tick;
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
